store_buffer_ctrl: RTL

STORE_BUFFER_CTRL -- requirements
Module: store_buffer_ctrl

---
 rtl/store_buffer_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/store_buffer_ctrl.sv
// store_buffer_ctrl
// Store queue between the core and memory. Each store is formatted into
// word address, lane-aligned data and byte strobes when it is accepted.
// Queued stores then go to memory one at a time, in acceptance order,
// over a req/ack handshake.
// Optional feature: define STORE_MISALIGN_TRAP_EN to reject misaligned SH
// and SW stores. A rejected store is not enqueued and causes a pulse on
// misalign. When the macro is not defined, misaligned stores are
// word-aligned and enqueued like any other store.
//
// state | meaning
// IDLE  | queue empty, no memory request
// REQ   | mem_req high, head entry on mem_addr/mem_wdata/mem_wstrb
module store_buffer_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_funct3,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    output logic        busy,
    output logic        misalign
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;

    logic [29:0]   q_addr  [DEPTH];
    logic [31:0]   q_wdata [DEPTH];
    logic [3:0]    q_wstrb [DEPTH];

    logic [31:0]   fmt_wdata;
    logic [3:0]    fmt_wstrb;
    logic          accept, push, pop, mis;

    // st_ready is based only on the registered count. A pop in the same
    // cycle does not free a slot for the current store.
    assign st_ready = (count != FULL);
    assign busy     = (count != '0);
    assign accept   = st_valid & st_ready;
    assign push     = accept & ~mis;
    assign pop      = (state == REQ) & mem_ack;

`ifdef STORE_MISALIGN_TRAP_EN
    logic misalign_q;

    assign mis = ((st_funct3 == 3'b001) && st_addr[0]) ||
                 ((st_funct3 == 3'b010) && (st_addr[1:0] != 2'b00));

    // Pulse misalign for one cycle after a rejected store completes its handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= accept & mis;
    end

    assign misalign = misalign_q;
`else
    assign mis      = 1'b0;
    assign misalign = 1'b0;
`endif

    // Format the store into lane-aligned data and byte strobes
    always_comb begin
        fmt_wdata = st_data;
        fmt_wstrb = 4'b1111;
        case (st_funct3)
            3'b000: begin
                fmt_wdata = {4{st_data[7:0]}};
                fmt_wstrb = 4'b0001 << st_addr[1:0];
            end
            3'b001: begin
                fmt_wdata = {2{st_data[15:0]}};
                fmt_wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Write the formatted store into queue storage (contents need no reset)
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr]  <= st_addr[31:2];
            q_wdata[wr_ptr] <= fmt_wdata;
            q_wstrb[wr_ptr] <= fmt_wstrb;
        end
    end

    // Next occupancy: a push and a pop on the same edge cancel out
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: ;
        endcase
    end

    // Pointers, occupancy and FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            state <= state_next;
        end
    end

    // Next state and memory-side outputs, driven from the head entry in REQ
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_wstrb  = 4'h0;
        case (state)
            IDLE: begin
                if (count_next != '0) state_next = REQ;
            end
            REQ: begin
                mem_req   = 1'b1;
                mem_addr  = {q_addr[rd_ptr], 2'b00};
                mem_wdata = q_wdata[rd_ptr];
                mem_wstrb = q_wstrb[rd_ptr];
                if (count_next == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
